// File: rtl/fpga_pkg.sv
// Shared definitions for the execution-core FPGA build: word width, word type
// and the ceil-log2 helper used to size pointers and counters.
package fpga_pkg;

    localparam int MemoryElementWidth = 12;

    typedef logic [MemoryElementWidth-1:0] word_t;

    // Smallest n with 2**n >= value; usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/in_channel_fifo_if.sv
// Producer/core side of the buffered input channel, grouped so the FIFO and its
// users can bind to one bundle through the master/slave modports.
interface in_channel_fifo_if
    import fpga_pkg::*;
#(
    parameter int Width      = MemoryElementWidth,
    parameter int SizeWidth  = 4,
    parameter int CountWidth = 16
) ();

    // Load handshake: a word transfers on every rising clock edge where
    // load_valid and load_ready are both high; load_data must be stable while
    // load_valid is high, and load_ready never depends on load_valid or pop.
    logic                  load_valid;
    logic [Width-1:0]      load_data;
    logic                  load_ready;

    logic                  flush;
    logic                  pop;
    logic [SizeWidth-1:0]  size;
    logic [Width-1:0]      head_data;
    logic                  underflow;
    logic [CountWidth-1:0] accepted;

    modport master (
        output load_valid,
        output load_data,
        output flush,
        output pop,
        input  load_ready,
        input  size,
        input  head_data,
        input  underflow,
        input  accepted
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  flush,
        input  pop,
        output load_ready,
        output size,
        output head_data,
        output underflow,
        output accepted
    );

endinterface

// File: rtl/channel_ram.sv
// Word storage for the input channel: one synchronous write port and an
// asynchronous read port so the head word is visible in the cycle it is popped.
module channel_ram
    import fpga_pkg::*;
#(
    parameter int Depth     = 8,
    parameter int Width     = MemoryElementWidth,
    parameter int AddrWidth = clog2(Depth)
) (
    input  logic                 clock,
    input  logic                 writeEnable,
    input  logic [AddrWidth-1:0] writeAddr,
    input  logic [Width-1:0]     writeData,
    input  logic [AddrWidth-1:0] readAddr,
    output logic [Width-1:0]     readData
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clock) begin
        if (writeEnable) begin
            mem[writeAddr] <= writeData;
        end
    end

    assign readData = mem[readAddr];

endmodule

// File: rtl/in_channel_fifo.sv
// Buffered input channel in front of the core's in/inSize instructions:
// first-word-fall-through FIFO with sticky underflow and a saturating accept count.
module in_channel_fifo
    import fpga_pkg::*;
#(
    parameter int MemoryElementWidth = fpga_pkg::MemoryElementWidth,
    parameter int Depth              = 8,
    parameter int CountWidth         = 16
) (
    input logic              clock,
    input logic              reset,
    in_channel_fifo_if.slave ch
);

    localparam int PtrWidth  = clog2(Depth);
    localparam int SizeWidth = clog2(Depth + 1);
    localparam logic [PtrWidth-1:0]  LastPtr   = PtrWidth'(Depth - 1);
    localparam logic [SizeWidth-1:0] DepthSize = SizeWidth'(Depth);

    logic [PtrWidth-1:0]           rdPtr;
    logic [PtrWidth-1:0]           wrPtr;
    logic [SizeWidth-1:0]          sizeReg;
    logic                          underflowReg;
    logic [CountWidth-1:0]         acceptedReg;
    logic [MemoryElementWidth-1:0] headHold;
    logic [MemoryElementWidth-1:0] ramReadData;

    logic notEmpty;
    logic loadReady;
    logic pushFire;
    logic popFire;
    logic popEmpty;

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrWidth'(1);
    endfunction

    assign notEmpty  = (sizeReg != '0);
    assign loadReady = (sizeReg < DepthSize) && !reset && !ch.flush;
    assign pushFire  = ch.load_valid && loadReady;
    assign popFire   = ch.pop && notEmpty && !ch.flush;
    assign popEmpty  = ch.pop && !notEmpty && !ch.flush;

    channel_ram #(
        .Depth(Depth),
        .Width(MemoryElementWidth),
        .AddrWidth(PtrWidth)
    ) ram (
        .clock(clock),
        .writeEnable(pushFire),
        .writeAddr(wrPtr),
        .writeData(ch.load_data),
        .readAddr(rdPtr),
        .readData(ramReadData)
    );

    always_ff @(posedge clock) begin
        if (reset || ch.flush) begin
            rdPtr        <= '0;
            wrPtr        <= '0;
            sizeReg      <= '0;
            underflowReg <= 1'b0;
            acceptedReg  <= '0;
        end else begin
            if (pushFire) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (popFire) begin
                rdPtr <= nextPtr(rdPtr);
            end
            if (pushFire && !popFire) begin
                sizeReg <= sizeReg + SizeWidth'(1);
            end else if (popFire && !pushFire) begin
                sizeReg <= sizeReg - SizeWidth'(1);
            end
            // A pop racing the first push still underflows: that word is not visible yet.
            if (popEmpty) begin
                underflowReg <= 1'b1;
            end
            if (pushFire && (acceptedReg != '1)) begin
                acceptedReg <= acceptedReg + CountWidth'(1);
            end
        end
    end

    // Remembers the last presented head so an empty channel leaves 'in' targets unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            headHold <= '0;
        end else if (notEmpty) begin
            headHold <= ramReadData;
        end
    end

    assign ch.load_ready = loadReady;
    assign ch.size       = sizeReg;
    assign ch.head_data  = notEmpty ? ramReadData : headHold;
    assign ch.underflow  = underflowReg;
    assign ch.accepted   = acceptedReg;

    sizeWithinDepth: assert property (@(posedge clock) disable iff (reset) sizeReg <= DepthSize);
    fullBlocksLoad: assert property (@(posedge clock) (sizeReg == DepthSize) |-> !loadReady);

endmodule

// File: tb/tb_in_channel_fifo.sv
// Directed bench for in_channel_fifo: an 8-deep instance for the main scenarios and a
// 3-deep instance with a 3-bit counter for non-power-of-two wrap and count saturation.
module tb_in_channel_fifo;
    import fpga_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   testsRun    = 0;
    int   testsFailed = 0;

    always #5 clock = ~clock;

    in_channel_fifo_if #(.Width(12), .SizeWidth(4), .CountWidth(16)) ch ();
    in_channel_fifo_if #(.Width(12), .SizeWidth(2), .CountWidth(3)) chSmall ();

    in_channel_fifo #(.Depth(8), .CountWidth(16)) dut (
        .clock(clock),
        .reset(reset),
        .ch(ch)
    );

    in_channel_fifo #(.Depth(3), .CountWidth(3)) dutSmall (
        .clock(clock),
        .reset(reset),
        .ch(chSmall)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        testsRun++; if (ch.load_ready !== 1'b0) begin testsFailed++; $display("FAIL reset_load_ready: got %0b expected 0", ch.load_ready); end
        testsRun++; if (ch.size !== 4'd0) begin testsFailed++; $display("FAIL reset_size: got %0d expected 0", ch.size); end
        testsRun++; if (ch.underflow !== 1'b0) begin testsFailed++; $display("FAIL reset_underflow: got %0b expected 0", ch.underflow); end
        testsRun++; if (ch.accepted !== 16'd0) begin testsFailed++; $display("FAIL reset_accepted: got %0d expected 0", ch.accepted); end
        testsRun++; if (ch.head_data !== 12'd0) begin testsFailed++; $display("FAIL reset_head: got %0d expected 0", ch.head_data); end
        reset = 1'b0;
        #1;
        testsRun++; if (ch.load_ready !== 1'b1) begin testsFailed++; $display("FAIL post_reset_load_ready: got %0b expected 1", ch.load_ready); end
    endtask

    task automatic test_push_three();
        word_t vals [3] = '{12'd33, 12'd22, 12'd11};
        for (int i = 0; i < 3; i++) begin
            ch.load_valid = 1'b1;
            ch.load_data  = vals[i];
            tick();
            testsRun++; if (ch.size !== 4'(i + 1)) begin testsFailed++; $display("FAIL push3_size_%0d: got %0d expected %0d", i, ch.size, i + 1); end
        end
        ch.load_valid = 1'b0;
        testsRun++; if (ch.head_data !== 12'd33) begin testsFailed++; $display("FAIL push3_head: got %0d expected 33", ch.head_data); end
        testsRun++; if (ch.accepted !== 16'd3) begin testsFailed++; $display("FAIL push3_accepted: got %0d expected 3", ch.accepted); end
        testsRun++; if (ch.load_ready !== 1'b1) begin testsFailed++; $display("FAIL push3_load_ready: got %0b expected 1", ch.load_ready); end
    endtask

    task automatic test_pop_order();
        word_t vals [3] = '{12'd33, 12'd22, 12'd11};
        for (int i = 0; i < 3; i++) begin
            ch.pop = 1'b1;
            testsRun++; if (ch.head_data !== vals[i]) begin testsFailed++; $display("FAIL pop_head_%0d: got %0d expected %0d", i, ch.head_data, vals[i]); end
            tick();
            testsRun++; if (ch.size !== 4'(2 - i)) begin testsFailed++; $display("FAIL pop_size_%0d: got %0d expected %0d", i, ch.size, 2 - i); end
        end
        ch.pop = 1'b0;
        testsRun++; if (ch.underflow !== 1'b0) begin testsFailed++; $display("FAIL pop_underflow: got %0b expected 0", ch.underflow); end
    endtask

    task automatic test_underflow();
        ch.pop = 1'b1;
        tick();
        ch.pop = 1'b0;
        testsRun++; if (ch.underflow !== 1'b1) begin testsFailed++; $display("FAIL underflow_set: got %0b expected 1", ch.underflow); end
        testsRun++; if (ch.head_data !== 12'd11) begin testsFailed++; $display("FAIL underflow_head: got %0d expected 11", ch.head_data); end
        testsRun++; if (ch.size !== 4'd0) begin testsFailed++; $display("FAIL underflow_size: got %0d expected 0", ch.size); end
        tick();
        tick();
        testsRun++; if (ch.underflow !== 1'b1) begin testsFailed++; $display("FAIL underflow_sticky: got %0b expected 1", ch.underflow); end
    endtask

    task automatic test_full();
        ch.flush = 1'b1;
        #1;
        testsRun++; if (ch.load_ready !== 1'b0) begin testsFailed++; $display("FAIL flush_load_ready: got %0b expected 0", ch.load_ready); end
        tick();
        ch.flush = 1'b0;
        testsRun++; if (ch.underflow !== 1'b0) begin testsFailed++; $display("FAIL flush_underflow: got %0b expected 0", ch.underflow); end
        testsRun++; if (ch.accepted !== 16'd0) begin testsFailed++; $display("FAIL flush_accepted: got %0d expected 0", ch.accepted); end
        for (int i = 0; i < 8; i++) begin
            ch.load_valid = 1'b1;
            ch.load_data  = 12'(i + 1);
            tick();
            testsRun++; if (ch.size !== 4'(i + 1)) begin testsFailed++; $display("FAIL fill_size_%0d: got %0d expected %0d", i, ch.size, i + 1); end
        end
        testsRun++; if (ch.load_ready !== 1'b0) begin testsFailed++; $display("FAIL full_load_ready: got %0b expected 0", ch.load_ready); end
        ch.load_data = 12'd9;
        tick();
        testsRun++; if (ch.size !== 4'd8) begin testsFailed++; $display("FAIL full_ninth_size: got %0d expected 8", ch.size); end
        testsRun++; if (ch.accepted !== 16'd8) begin testsFailed++; $display("FAIL full_ninth_accepted: got %0d expected 8", ch.accepted); end
        ch.pop = 1'b1;
        testsRun++; if (ch.head_data !== 12'd1) begin testsFailed++; $display("FAIL full_pop_head: got %0d expected 1", ch.head_data); end
        tick();
        ch.pop = 1'b0;
        testsRun++; if (ch.size !== 4'd7) begin testsFailed++; $display("FAIL full_pop_size: got %0d expected 7", ch.size); end
        testsRun++; if (ch.load_ready !== 1'b1) begin testsFailed++; $display("FAIL full_reopen_ready: got %0b expected 1", ch.load_ready); end
        tick();
        ch.load_valid = 1'b0;
        testsRun++; if (ch.size !== 4'd8) begin testsFailed++; $display("FAIL full_refill_size: got %0d expected 8", ch.size); end
        testsRun++; if (ch.accepted !== 16'd9) begin testsFailed++; $display("FAIL full_refill_accepted: got %0d expected 9", ch.accepted); end
        for (int i = 0; i < 8; i++) begin
            ch.pop = 1'b1;
            testsRun++; if (ch.head_data !== 12'(i + 2)) begin testsFailed++; $display("FAIL full_drain_head_%0d: got %0d expected %0d", i, ch.head_data, i + 2); end
            tick();
        end
        ch.pop = 1'b0;
        testsRun++; if (ch.size !== 4'd0) begin testsFailed++; $display("FAIL full_drain_size: got %0d expected 0", ch.size); end
    endtask

    task automatic test_push_pop_empty();
        ch.load_valid = 1'b1;
        ch.load_data  = 12'd77;
        ch.pop        = 1'b1;
        tick();
        ch.load_valid = 1'b0;
        ch.pop        = 1'b0;
        testsRun++; if (ch.size !== 4'd1) begin testsFailed++; $display("FAIL pp_empty_size: got %0d expected 1", ch.size); end
        testsRun++; if (ch.underflow !== 1'b1) begin testsFailed++; $display("FAIL pp_empty_underflow: got %0b expected 1", ch.underflow); end
        testsRun++; if (ch.head_data !== 12'd77) begin testsFailed++; $display("FAIL pp_empty_head: got %0d expected 77", ch.head_data); end
        ch.flush = 1'b1;
        tick();
        ch.flush = 1'b0;
        testsRun++; if (ch.size !== 4'd0) begin testsFailed++; $display("FAIL pp_flush_size: got %0d expected 0", ch.size); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            ch.load_valid = 1'b1;
            ch.load_data  = 12'(100 + i);
            tick();
        end
        for (int i = 0; i < 24; i++) begin
            ch.load_valid = 1'b1;
            ch.load_data  = 12'(104 + i);
            ch.pop        = 1'b1;
            testsRun++; if (ch.head_data !== 12'(100 + i)) begin testsFailed++; $display("FAIL b2b_head_%0d: got %0d expected %0d", i, ch.head_data, 100 + i); end
            tick();
            testsRun++; if (ch.size !== 4'd4) begin testsFailed++; $display("FAIL b2b_size_%0d: got %0d expected 4", i, ch.size); end
        end
        ch.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ch.pop = 1'b1;
            testsRun++; if (ch.head_data !== 12'(124 + i)) begin testsFailed++; $display("FAIL b2b_drain_%0d: got %0d expected %0d", i, ch.head_data, 124 + i); end
            tick();
        end
        ch.pop = 1'b0;
        testsRun++; if (ch.size !== 4'd0) begin testsFailed++; $display("FAIL b2b_final_size: got %0d expected 0", ch.size); end
        testsRun++; if (ch.accepted !== 16'd28) begin testsFailed++; $display("FAIL b2b_accepted: got %0d expected 28", ch.accepted); end
    endtask

    task automatic test_flush_reset();
        for (int mode = 0; mode < 2; mode++) begin
            ch.pop = 1'b1;
            tick();
            tick();
            ch.pop = 1'b0;
            testsRun++; if (ch.underflow !== 1'b1) begin testsFailed++; $display("FAIL clear%0d_pre_underflow: got %0b expected 1", mode, ch.underflow); end
            for (int i = 0; i < 5; i++) begin
                ch.load_valid = 1'b1;
                ch.load_data  = 12'(40 + i);
                tick();
            end
            testsRun++; if (ch.size !== 4'd5) begin testsFailed++; $display("FAIL clear%0d_pre_size: got %0d expected 5", mode, ch.size); end
            ch.load_data = 12'd55;
            ch.pop       = 1'b1;
            if (mode == 0) ch.flush = 1'b1; else reset = 1'b1;
            #1;
            testsRun++; if (ch.load_ready !== 1'b0) begin testsFailed++; $display("FAIL clear%0d_load_ready: got %0b expected 0", mode, ch.load_ready); end
            tick();
            ch.flush      = 1'b0;
            reset         = 1'b0;
            ch.load_valid = 1'b0;
            ch.pop        = 1'b0;
            #1;
            testsRun++; if (ch.size !== 4'd0) begin testsFailed++; $display("FAIL clear%0d_size: got %0d expected 0", mode, ch.size); end
            testsRun++; if (ch.accepted !== 16'd0) begin testsFailed++; $display("FAIL clear%0d_accepted: got %0d expected 0", mode, ch.accepted); end
            testsRun++; if (ch.underflow !== 1'b0) begin testsFailed++; $display("FAIL clear%0d_underflow: got %0b expected 0", mode, ch.underflow); end
            testsRun++; if (ch.load_ready !== 1'b1) begin testsFailed++; $display("FAIL clear%0d_ready: got %0b expected 1", mode, ch.load_ready); end
            ch.load_valid = 1'b1;
            ch.load_data  = 12'd7;
            tick();
            ch.load_valid = 1'b0;
            testsRun++; if (ch.head_data !== 12'd7) begin testsFailed++; $display("FAIL clear%0d_head: got %0d expected 7", mode, ch.head_data); end
            testsRun++; if (ch.size !== 4'd1) begin testsFailed++; $display("FAIL clear%0d_post_size: got %0d expected 1", mode, ch.size); end
            testsRun++; if (ch.accepted !== 16'd1) begin testsFailed++; $display("FAIL clear%0d_post_accepted: got %0d expected 1", mode, ch.accepted); end
        end
    endtask

    task automatic test_small_wrap();
        chSmall.flush = 1'b1;
        tick();
        chSmall.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chSmall.load_valid = 1'b1;
            chSmall.load_data  = 12'(200 + i);
            tick();
        end
        chSmall.load_valid = 1'b0;
        testsRun++; if (chSmall.size !== 2'd3) begin testsFailed++; $display("FAIL small_full_size: got %0d expected 3", chSmall.size); end
        testsRun++; if (chSmall.load_ready !== 1'b0) begin testsFailed++; $display("FAIL small_full_ready: got %0b expected 0", chSmall.load_ready); end
        testsRun++; if (chSmall.accepted !== 3'd3) begin testsFailed++; $display("FAIL small_accepted3: got %0d expected 3", chSmall.accepted); end
        chSmall.pop = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            chSmall.load_valid = 1'b1;
            chSmall.load_data  = 12'(203 + i);
            chSmall.pop        = 1'b1;
            testsRun++; if (chSmall.head_data !== 12'(201 + i)) begin testsFailed++; $display("FAIL small_head_%0d: got %0d expected %0d", i, chSmall.head_data, 201 + i); end
            tick();
            testsRun++; if (chSmall.size !== 2'd2) begin testsFailed++; $display("FAIL small_size_%0d: got %0d expected 2", i, chSmall.size); end
        end
        chSmall.load_valid = 1'b0;
        testsRun++; if (chSmall.accepted !== 3'd7) begin testsFailed++; $display("FAIL small_saturate: got %0d expected 7", chSmall.accepted); end
        for (int i = 0; i < 2; i++) begin
            chSmall.pop = 1'b1;
            testsRun++; if (chSmall.head_data !== 12'(207 + i)) begin testsFailed++; $display("FAIL small_drain_%0d: got %0d expected %0d", i, chSmall.head_data, 207 + i); end
            tick();
        end
        chSmall.pop = 1'b0;
        testsRun++; if (chSmall.size !== 2'd0) begin testsFailed++; $display("FAIL small_final_size: got %0d expected 0", chSmall.size); end
        testsRun++; if (chSmall.underflow !== 1'b0) begin testsFailed++; $display("FAIL small_underflow: got %0b expected 0", chSmall.underflow); end
    endtask

    initial begin
        reset              = 1'b1;
        ch.load_valid      = 1'b0;
        ch.load_data       = '0;
        ch.flush           = 1'b0;
        ch.pop             = 1'b0;
        chSmall.load_valid = 1'b0;
        chSmall.load_data  = '0;
        chSmall.flush      = 1'b0;
        chSmall.pop        = 1'b0;

        test_reset();
        test_push_three();
        test_pop_order();
        test_underflow();
        test_full();
        test_push_pop_empty();
        test_back_to_back();
        test_flush_reset();
        test_small_wrap();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
